// File: rtl/lgv8_chk_pkg.sv
// Shared types for the LEGv8 writeback checker.
//   state_t    : checker FSM states
//   err_code_t : error classification reported on err_code
//   XZR_IDX    : zero-register index; writes to it are never checked
package lgv8_chk_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_MISMATCH   = 2'd1,
        ERR_UNEXPECTED = 2'd2
    } err_code_t;

    localparam int XZR_IDX = 31;
endpackage

// File: rtl/wb_exp_fifo.sv
// Synchronous FIFO of expected writeback entries.
//   clk, rst     : clock, async active-high reset
//   flush        : synchronous empty (pointers and count to zero)
//   push, din    : write an entry (ignored when full)
//   pop, dout    : dout is the head entry; pop advances it (ignored when empty)
//   full, empty  : occupancy flags
//   level        : number of stored entries, 0..DEPTH
module wb_exp_fifo #(
    parameter  int W     = 69,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            // simultaneous push and pop leave the count unchanged
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // storage needs no reset; only slots behind valid pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/wb_check_unit.sv
// Writeback checker: compares qualifying register-file writes against an
// ordered queue of expected (reg, data) pairs.
//   exp_valid/exp_ready, exp_reg, exp_data : expected-entry push
//   start / clear                          : arm checking / flush everything
//   wb_en, wb_reg, wb_data                 : core writeback port
//   filter_en, filter_reg                  : restrict checking to one register
//   busy, done, pass, timeout              : status
//   err_valid, err_code                    : per-mismatch pulse; last error class
//   first_err_idx/got/exp                  : capture of the first mismatch
//   pass_cnt, fail_cnt                     : saturating result counters
//   level                                  : expected-queue occupancy
module wb_check_unit
    import lgv8_chk_pkg::*;
#(
    parameter  int WORD         = 64,
    parameter  int REG_W        = 5,
    parameter  int DEPTH        = 16,
    parameter  int TIMEOUT      = 1024,
    parameter  int STOP_ON_FAIL = 1,
    localparam int LW           = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [REG_W-1:0] exp_reg,
    input  logic [WORD-1:0]  exp_data,
    input  logic             start,
    input  logic             clear,
    input  logic             wb_en,
    input  logic [REG_W-1:0] wb_reg,
    input  logic [WORD-1:0]  wb_data,
    input  logic             filter_en,
    input  logic [REG_W-1:0] filter_reg,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic [15:0]      first_err_idx,
    output logic [WORD-1:0]  first_err_got,
    output logic [WORD-1:0]  first_err_exp,
    output logic [15:0]      pass_cnt,
    output logic [15:0]      fail_cnt,
    output logic [LW-1:0]    level
);
    typedef struct packed {
        logic [REG_W-1:0] rg;
        logic [WORD-1:0]  data;
    } entry_t;

    state_t      state, state_nxt;
    entry_t      head, push_ent;
    logic        full, empty;
    logic        qual, chk, pop, match, mism, push, drains, to_hit;
    logic [31:0] idle_cnt;
    logic [15:0] chk_idx;

    assign push_ent = '{rg: exp_reg, data: exp_data};

    wb_exp_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign qual   = wb_en && (wb_reg != REG_W'(XZR_IDX))
                    && (!filter_en || wb_reg == filter_reg);
    assign chk    = (state == ST_RUN) && qual && !clear;
    assign pop    = chk && !empty;
    assign match  = pop && (wb_reg == head.rg) && (wb_data == head.data);
    assign mism   = chk && !match;
    assign exp_ready = !full && (state != ST_DONE);
    assign push   = exp_valid && exp_ready && !clear;
    // the pop that leaves the queue empty ends the run; a same-cycle push keeps it alive
    assign drains = pop && (level == LW'(1)) && !push;
    assign to_hit = (TIMEOUT != 0) && (state == ST_RUN) && !qual
                    && (idle_cnt == 32'(TIMEOUT - 1));

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign pass = done && (fail_cnt == '0) && !timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (drains || (mism && STOP_ON_FAIL != 0) || to_hit)
                         state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
        if (clear) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt      <= '0;
            chk_idx       <= '0;
            timeout       <= 1'b0;
            err_valid     <= 1'b0;
            err_code      <= ERR_NONE;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
        end else if (clear) begin
            idle_cnt      <= '0;
            chk_idx       <= '0;
            timeout       <= 1'b0;
            err_valid     <= 1'b0;
            err_code      <= ERR_NONE;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
        end else begin
            err_valid <= mism;
            if (state == ST_IDLE && start) begin
                idle_cnt <= '0;
                chk_idx  <= '0;
            end
            if (state == ST_RUN) idle_cnt <= qual ? '0 : idle_cnt + 1'b1;
            if (to_hit) timeout <= 1'b1;
            if (chk && chk_idx != '1) chk_idx <= chk_idx + 1'b1;
            if (match && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            if (mism) begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                // err_code holds the class of the most recent error
                err_code <= empty ? ERR_UNEXPECTED : ERR_MISMATCH;
                if (fail_cnt == '0) begin
                    first_err_idx <= chk_idx;
                    first_err_got <= wb_data;
                    first_err_exp <= empty ? '0 : head.data;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_check_unit.sv
module tb_wb_check_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exp_valid = 1'b0, exp_ready;
    logic [4:0]  exp_reg = '0;
    logic [63:0] exp_data = '0;
    logic        start = 1'b0, clear = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [63:0] wb_data = '0;
    logic        filter_en = 1'b0;
    logic [4:0]  filter_reg = '0;
    logic        busy, done, pass, timeout, err_valid;
    logic [1:0]  err_code;
    logic [15:0] first_err_idx, pass_cnt, fail_cnt;
    logic [63:0] first_err_got, first_err_exp;
    logic [3:0]  level;

    int tests = 0;
    int fails = 0;

    wb_check_unit #(.WORD(64), .REG_W(5), .DEPTH(8), .TIMEOUT(8), .STOP_ON_FAIL(1)) dut (
        .clk(clk), .rst(rst),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_reg(exp_reg), .exp_data(exp_data),
        .start(start), .clear(clear),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .filter_en(filter_en), .filter_reg(filter_reg),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_valid(err_valid), .err_code(err_code),
        .first_err_idx(first_err_idx), .first_err_got(first_err_got), .first_err_exp(first_err_exp),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [63:0] d);
        exp_valid = 1'b1; exp_reg = r; exp_data = d;
        tick(1);
        exp_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [63:0] d);
        wb_en = 1'b1; wb_reg = r; wb_data = d;
        tick(1);
        wb_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(1); clear = 1'b0;
    endtask

    initial begin
        // reset state
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_level", level, 0);
        check("rst_ready", exp_ready, 1);
        check("rst_cnts", {pass_cnt, fail_cnt}, 0);
        check("rst_code", err_code, 0);

        // bubble sort: five matching writes drain the queue
        push(9, 64'h1); push(9, 64'h2); push(9, 64'h27); push(9, 64'h45); push(9, 64'h99);
        check("bs_level5", level, 5);
        do_start();
        check("bs_busy", busy, 1);
        wb(9, 64'h1); wb(9, 64'h2); wb(9, 64'h27); wb(9, 64'h45);
        check("bs_not_done", done, 0);
        wb(9, 64'h99);
        check("bs_pass_cnt", pass_cnt, 5);
        check("bs_fail_cnt", fail_cnt, 0);
        check("bs_done", done, 1);
        check("bs_pass", pass, 1);
        check("bs_busy_low", busy, 0);
        check("bs_level0", level, 0);
        check("bs_ready_done", exp_ready, 0);
        check("bs_no_err", err_valid, 0);
        do_clear();
        check("clr_done", done, 0);
        check("clr_pass_cnt", pass_cnt, 0);
        check("clr_ready", exp_ready, 1);

        // data mismatch stops the run
        push(9, 64'h6);
        do_start();
        wb(9, 64'h5);
        check("mm_err_valid", err_valid, 1);
        check("mm_err_code", err_code, 1);
        check("mm_got", first_err_got, 64'h5);
        check("mm_exp", first_err_exp, 64'h6);
        check("mm_idx", first_err_idx, 0);
        check("mm_fail_cnt", fail_cnt, 1);
        check("mm_done", done, 1);
        check("mm_pass", pass, 0);
        tick(1);
        check("mm_pulse_end", err_valid, 0);
        check("mm_code_held", err_code, 1);
        do_clear();

        // filter on X9: X31 and X3 writes are ignored
        filter_en = 1'b1; filter_reg = 9;
        push(9, 64'hA); push(9, 64'hB);
        do_start();
        wb(31, 64'h123); wb(3, 64'h5); wb(9, 64'hA);
        wb(31, 64'h0); wb(3, 64'h7); wb(9, 64'hB);
        check("flt_pass_cnt", pass_cnt, 2);
        check("flt_fail_cnt", fail_cnt, 0);
        check("flt_pass", pass, 1);
        filter_en = 1'b0;
        do_clear();

        // unexpected write with empty queue; XZR write first is ignored
        do_start();
        wb(31, 64'h1);
        check("ue_xzr_fail", fail_cnt, 0);
        check("ue_xzr_busy", busy, 1);
        wb(9, 64'h1);
        check("ue_err_code", err_code, 2);
        check("ue_fail_cnt", fail_cnt, 1);
        check("ue_level", level, 0);
        check("ue_got", first_err_got, 64'h1);
        check("ue_exp", first_err_exp, 64'h0);
        check("ue_done", done, 1);
        do_clear();

        // full queue, then simultaneous push/pop
        for (int i = 0; i < 8; i++) push(9, 64'(i));
        check("fq_level8", level, 8);
        check("fq_ready0", exp_ready, 0);
        do_start();
        exp_valid = 1'b1; exp_reg = 9; exp_data = 64'h100;
        wb_en = 1'b1; wb_reg = 9; wb_data = 64'h0;
        tick(1);
        check("fq_pop_only", level, 7);
        check("fq_ready1", exp_ready, 1);
        wb_data = 64'h1;
        tick(1);
        exp_valid = 1'b0; wb_en = 1'b0;
        check("fq_push_pop", level, 7);
        for (int i = 2; i < 8; i++) wb(9, 64'(i));
        check("fq_not_done", done, 0);
        wb(9, 64'h100);
        check("fq_pass_cnt", pass_cnt, 9);
        check("fq_fail_cnt", fail_cnt, 0);
        check("fq_pass", pass, 1);
        do_clear();

        // timeout after 8 idle RUN cycles
        push(9, 64'h1);
        do_start();
        tick(7);
        check("to_early", done, 0);
        tick(1);
        check("to_done", done, 1);
        check("to_flag", timeout, 1);
        check("to_pass", pass, 0);
        check("to_level", level, 1);
        do_clear();
        check("to_clr_busy", busy, 0);
        check("to_clr_done", done, 0);
        check("to_clr_flag", timeout, 0);
        check("to_clr_level", level, 0);

        // async reset mid-run
        push(9, 64'h1); push(9, 64'h2);
        do_start();
        wb(9, 64'h1);
        check("ar_pre_cnt", pass_cnt, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_pass_cnt", pass_cnt, 0);
        check("ar_busy", busy, 0);
        check("ar_level", level, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("ar_idle", {busy, done}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
